debug_reg_dumper: RTL and testbench

Debug readout engine for the MIPS core. On a start request it walks every register-file entry through the register file's debug read port and serialises each 32-bit value, MSB byte first, onto a byte-wide valid/ready transmit stream. After the last register it appends one XOR checksum byte. It sits between the core's debug read port and the host-link transmitter, and is the read-back counterpart of the instruction/data loader path.

---
 rtl/debug_reg_dumper.sv | 128 ++++++++++++
 tb/tb_debug_reg_dumper.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/debug_reg_dumper.sv
// Debug register dumper: walks every register-file entry through the debug
// read port and streams each word MSB byte first over a byte-wide valid/ready
// link, followed by one XOR checksum byte over all data bytes.
module debug_reg_dumper #(
  parameter int unsigned NB_DATA = 32,
  parameter int unsigned NB_REG  = 5,
  parameter int unsigned N_REGS  = 32,
  parameter int unsigned NB_BYTE = 8
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_start,
  output logic               o_busy,
  output logic               o_done,
  output logic [NB_REG-1:0]  o_address_read_debug,
  input  logic [NB_DATA-1:0] i_data_read_debug,
  output logic [NB_BYTE-1:0] o_tx_data,
  output logic               o_tx_valid,
  input  logic               i_tx_ready
);

  localparam int unsigned NBytes = NB_DATA / NB_BYTE;
  localparam int unsigned NbCnt  = (NBytes > 1) ? $clog2(NBytes) : 1;

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StLatch,
    StSend,
    StNext,
    StCsum,
    StDone
  } state_e;

  state_e             r_state, w_state_next;
  logic [NB_REG-1:0]  r_idx, w_idx_next;
  logic [NbCnt-1:0]   r_byte_cnt, w_byte_cnt_next;
  logic [NB_DATA-1:0] r_shift, w_shift_next;
  logic [NB_BYTE-1:0] r_csum, w_csum_next;

  // The address is the registered index, so it is stable for the whole word.
  assign o_address_read_debug = r_idx;

  // State and datapath registers; reset aborts any dump in progress.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state    <= StIdle;
      r_idx      <= '0;
      r_byte_cnt <= '0;
      r_shift    <= '0;
      r_csum     <= '0;
    end else begin
      r_state    <= w_state_next;
      r_idx      <= w_idx_next;
      r_byte_cnt <= w_byte_cnt_next;
      r_shift    <= w_shift_next;
      r_csum     <= w_csum_next;
    end
  end

  // Next-state and outputs; o_tx_valid depends on state only, never on ready.
  always_comb begin
    w_state_next    = r_state;
    w_idx_next      = r_idx;
    w_byte_cnt_next = r_byte_cnt;
    w_shift_next    = r_shift;
    w_csum_next     = r_csum;
    o_busy          = 1'b1;
    o_done          = 1'b0;
    o_tx_valid      = 1'b0;
    o_tx_data       = '0;

    unique case (r_state)
      StIdle: begin
        o_busy = 1'b0;
        if (i_start) begin
          w_idx_next   = '0;
          w_csum_next  = '0;
          w_state_next = StAddr;
        end
      end
      StAddr: begin
        w_state_next = StLatch;
      end
      StLatch: begin
        // Read data for the address presented in StAddr is valid now.
        w_shift_next    = i_data_read_debug;
        w_byte_cnt_next = '0;
        w_state_next    = StSend;
      end
      StSend: begin
        o_tx_valid = 1'b1;
        o_tx_data  = r_shift[NB_DATA-1 -: NB_BYTE];
        if (i_tx_ready) begin
          w_shift_next    = r_shift << NB_BYTE;
          w_csum_next     = r_csum ^ r_shift[NB_DATA-1 -: NB_BYTE];
          w_byte_cnt_next = r_byte_cnt + NbCnt'(1);
          if (r_byte_cnt == NbCnt'(NBytes - 1)) begin
            w_state_next = StNext;
          end
        end
      end
      StNext: begin
        if (r_idx == NB_REG'(N_REGS - 1)) begin
          w_state_next = StCsum;
        end else begin
          w_idx_next   = r_idx + NB_REG'(1);
          w_state_next = StAddr;
        end
      end
      StCsum: begin
        o_tx_valid = 1'b1;
        o_tx_data  = r_csum;
        if (i_tx_ready) begin
          w_state_next = StDone;
        end
      end
      StDone: begin
        o_done       = 1'b1;
        w_state_next = StIdle;
      end
      default: begin
        w_state_next = StIdle;
      end
    endcase
  end

endmodule

// File: tb/tb_debug_reg_dumper.sv
// Scoreboard bench for debug_reg_dumper: stimulus pushes the expected byte
// stream into a queue, a negedge monitor pops and compares each accepted byte.
module tb_debug_reg_dumper;

  localparam int unsigned NRegs = 32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        busy;
  logic        done;
  logic [4:0]  addr;
  logic [31:0] rd_data;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b1;

  logic [31:0] mem [NRegs];
  logic [7:0]  exp_q [$];

  int checks    = 0;
  int errors    = 0;
  int cyc       = 0;
  int stalls    = 0;
  int done_cnt  = 0;
  int done_cyc  = 0;
  bit bp_mode   = 1'b0;
  bit prev_stall = 1'b0;
  bit prev_busy  = 1'b0;
  logic [7:0] prev_data = '0;
  logic [4:0] prev_addr = '0;

  debug_reg_dumper dut (
    .i_clk                (clk),
    .i_reset              (rst_n),
    .i_start              (start),
    .o_busy               (busy),
    .o_done               (done),
    .o_address_read_debug (addr),
    .i_data_read_debug    (rd_data),
    .o_tx_data            (tx_data),
    .o_tx_valid           (tx_valid),
    .i_tx_ready           (tx_ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Register file debug port with one cycle of read latency.
  always @(posedge clk) rd_data <= mem[addr];

  // Ready changes just after the active edge so it is stable at the monitor.
  always @(posedge clk) begin
    #1;
    tx_ready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: byte scoreboard, hold-while-stalled, address stepping, done pulses.
  always @(negedge clk) begin
    if (rst_n) begin
      if (prev_stall) begin
        check("hold_valid", 32'(tx_valid), 32'd1);
        check("hold_data", 32'(tx_data), 32'(prev_data));
      end
      if (tx_valid && tx_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_byte: got %0h expected no byte", tx_data);
        end else begin
          check("tx_byte", 32'(tx_data), 32'(exp_q.pop_front()));
        end
      end
      if (tx_valid && !tx_ready) stalls++;
      if (busy && !prev_busy) check("addr_start", 32'(addr), 32'd0);
      else if (busy && addr != prev_addr) check("addr_step", 32'(addr), 32'(prev_addr) + 1);
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        check("addr_at_done", 32'(addr), NRegs - 1);
      end
      prev_stall = tx_valid && !tx_ready;
      prev_data  = tx_data;
      prev_busy  = busy;
      prev_addr  = addr;
    end else begin
      prev_stall = 1'b0;
      prev_busy  = 1'b0;
    end
  end

  task automatic load_expected();
    logic [7:0]  cs;
    logic [31:0] w;
    logic [7:0]  b;
    cs = '0;
    exp_q.delete();
    for (int i = 0; i < NRegs; i++) begin
      w = mem[i];
      for (int k = 0; k < 4; k++) begin
        b = w[31 - 8 * k -: 8];
        exp_q.push_back(b);
        cs ^= b;
      end
    end
    exp_q.push_back(cs);
  endtask

  // Issue start; c0 is the cycle count right after the edge that samples it.
  task automatic issue_start(output int c0);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    c0    = cyc;
    start = 1'b0;
    check("busy_after_start", 32'(busy), 32'd1);
  endtask

  task automatic run_dump(input bit bp, input bit dbl);
    int c0;
    load_expected();
    stalls   = 0;
    done_cnt = 0;
    bp_mode  = bp;
    issue_start(c0);
    if (dbl) begin
      repeat (49) @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
    end
    for (int k = 0; k < 5000 && done_cnt == 0; k++) @(negedge clk);
    repeat (4) @(negedge clk);
    bp_mode = 1'b0;
    check("done_pulses", 32'(done_cnt), 32'd1);
    check("done_edge", 32'(done_cyc - c0), 32'(225 + stalls));
    check("bytes_left", 32'(exp_q.size()), 32'd0);
    check("busy_after_done", 32'(busy), 32'd0);
    check("valid_idle", 32'(tx_valid), 32'd0);
  endtask

  initial begin
    int c0;
    rst_n = 1'b0;
    start = 1'b0;
    for (int i = 0; i < NRegs; i++) mem[i] = '0;
    mem[1] = 32'h1234_5678;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_valid", 32'(tx_valid), 32'd0);
    check("rst_data", 32'(tx_data), 32'd0);
    check("rst_addr", 32'(addr), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_busy", 32'(busy), 32'd0);

    // Full dump, backpressure, start while busy
    run_dump(1'b0, 1'b0);
    run_dump(1'b1, 1'b0);
    run_dump(1'b0, 1'b1);

    // Reset in the middle of register 10's SEND phase
    load_expected();
    issue_start(c0);
    repeat (73) @(posedge clk);
    #2;
    check("pre_rst_valid", 32'(tx_valid), 32'd1);
    check("pre_rst_addr", 32'(addr), 32'd10);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_valid", 32'(tx_valid), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_data", 32'(tx_data), 32'd0);
    check("midrst_addr", 32'(addr), 32'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run_dump(1'b0, 1'b0);

    // Address sequencing with r[i] = i
    for (int i = 0; i < NRegs; i++) mem[i] = 32'(i);
    run_dump(1'b0, 1'b0);
    run_dump(1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
